// File: rtl/lcd_bus_scheduler.sv
// HD44780-style LCD write scheduler: power-up wait, fixed init sequence, then
// two-requester arbitration onto a single write-only LCD bus with setup,
// enable-pulse, hold and execution timing.
// Optional build macro: LCD_SCHED_RR_EN selects round-robin arbitration;
// when undefined, requester 0 has fixed priority over requester 1.
module lcd_bus_scheduler #(
  parameter int unsigned PWR_WAIT = 1000,
  parameter int unsigned T_SU     = 2,
  parameter int unsigned T_PW     = 8,
  parameter int unsigned T_HOLD   = 2,
  parameter int unsigned T_EXEC   = 100,
  parameter int unsigned T_CLR    = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_dat,
  output logic       busy,
  output logic       init_done
);

  // Counters run 0..N-1 in each timed state, so compare against N-1.
  localparam logic [15:0] PwrLim  = 16'(PWR_WAIT - 1);
  localparam logic [15:0] SuLim   = 16'(T_SU - 1);
  localparam logic [15:0] PwLim   = 16'(T_PW - 1);
  localparam logic [15:0] HoldLim = 16'(T_HOLD - 1);
  localparam logic [15:0] ExecLim = 16'(T_EXEC - 1);
  localparam logic [15:0] ClrLim  = 16'(T_CLR - 1);

  typedef enum logic [2:0] {StPwrw, StIdle, StSetup, StPulse, StHold, StExec} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        init_done_q, init_done_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic [7:0]  lcd_dat_q, lcd_dat_d;
  logic        lcd_en_q, lcd_en_d;
  logic        grant0, grant1;
  logic        xfer0, xfer1;
  logic        idle_ok;
  logic [15:0] lim;
  logic        last;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

`ifdef LCD_SCHED_RR_EN
  logic rr_q, rr_d;  // 1 = requester 1 preferred on a tie

  assign grant0 = req0_valid & (~req1_valid | ~rr_q);
  assign grant1 = req1_valid & (~req0_valid | rr_q);

  // Pointer moves only on an actual transfer, away from the requester served.
  always_comb begin
    rr_d = rr_q;
    if (xfer0)      rr_d = 1'b1;
    else if (xfer1) rr_d = 1'b0;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`else
  assign grant0 = req0_valid;
  assign grant1 = req1_valid & ~req0_valid;
`endif

  assign idle_ok    = (state_q == StIdle) && init_done_q;
  assign req0_ready = idle_ok & grant0;
  assign req1_ready = idle_ok & grant1;
  assign xfer0      = req0_valid & req0_ready;
  assign xfer1      = req1_valid & req1_ready;

  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = lcd_en_q;
  assign lcd_dat   = lcd_dat_q;
  assign busy      = (state_q != StIdle);
  assign init_done = init_done_q;

  // Duration of the current timed state; clear/home need the long wait.
  always_comb begin
    lim = 16'd0;
    unique case (state_q)
      StPwrw:  lim = PwrLim;
      StSetup: lim = SuLim;
      StPulse: lim = PwLim;
      StHold:  lim = HoldLim;
      StExec:  lim = (!lcd_rs_q && (lcd_dat_q == 8'h01 || lcd_dat_q == 8'h02)) ? ClrLim
                                                                               : ExecLim;
      default: lim = 16'd0;
    endcase
    last = (cnt_q == lim);
  end

  // Next-state logic for the sequencer, counters and bus registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = last ? 16'd0 : cnt_q + 16'd1;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_dat_d   = lcd_dat_q;
    unique case (state_q)
      StPwrw: begin
        if (last) begin
          state_d   = StSetup;
          lcd_rs_d  = 1'b0;
          lcd_dat_d = init_byte(idx_q);
        end
      end
      StIdle: begin
        cnt_d = 16'd0;
        if (xfer0) begin
          state_d   = StSetup;
          lcd_rs_d  = req0_rs;
          lcd_dat_d = req0_data;
        end else if (xfer1) begin
          state_d   = StSetup;
          lcd_rs_d  = req1_rs;
          lcd_dat_d = req1_data;
        end
      end
      StSetup: if (last) state_d = StPulse;
      StPulse: if (last) state_d = StHold;
      StHold:  if (last) state_d = StExec;
      StExec: begin
        if (last) begin
          if (!init_done_q && idx_q != 2'd3) begin
            // Chain straight into the next init byte.
            idx_d     = idx_q + 2'd1;
            state_d   = StSetup;
            lcd_rs_d  = 1'b0;
            lcd_dat_d = init_byte(idx_q + 2'd1);
          end else begin
            init_done_d = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      default: begin
        state_d = StPwrw;
        cnt_d   = 16'd0;
      end
    endcase
    lcd_en_d = (state_d == StPulse);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StPwrw;
      cnt_q       <= 16'd0;
      idx_q       <= 2'd0;
      init_done_q <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_dat_q   <= 8'h00;
      lcd_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_dat_q   <= lcd_dat_d;
      lcd_en_q    <= lcd_en_d;
    end
  end

endmodule
